// File: rtl/spiflash_prog_seq_if.sv
// Wishbone link from the sequencer to the spiflash config port.
interface spiflash_prog_seq_if;
  logic        cyc;
  logic        cfg_stb;
  logic        we;
  logic [31:0] odata;   // {23'b0, cs_release, byte}
  logic        stall;
  logic        ack;
  logic [31:0] idata;   // [7:0] = byte shifted in

  modport master (output cyc, cfg_stb, we, odata, input stall, ack, idata);
  modport slave  (input cyc, cfg_stb, we, odata, output stall, ack, idata);
endinterface

// File: rtl/spiflash_prog_seq.sv
// Flash management sequencer: expands STATUS / ERASE_4K / PROGRAM commands
// into spiflash config-port byte transfers and polls WIP until it clears.
module spiflash_prog_seq #(
  parameter int POLL_LIMIT = 2000000,
  parameter int POLL_W     = $clog2(POLL_LIMIT+1)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [23:0] i_cmd_addr,
  input  logic [8:0]  i_cmd_len,
  input  logic        i_wdata_valid,
  output logic        o_wdata_ready,
  input  logic [7:0]  i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_status,
  spiflash_prog_seq_if.master sf
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_STB, S_ACK, S_DONE} state_t;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_PROG   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Byte slots of the SPI sequence; STATUS enters directly at ST_RDSR and
  // shares the poll tail with a single unconditional read.
  localparam logic [3:0] ST_WREN = 4'd0, ST_WREL = 4'd1, ST_OPC  = 4'd2,
                         ST_A2   = 4'd3, ST_A1   = 4'd4, ST_A0   = 4'd5,
                         ST_DATA = 4'd6, ST_CREL = 4'd7, ST_RDSR = 4'd8,
                         ST_POLL = 4'd9, ST_PREL = 4'd10;

  state_t            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [1:0]        op_q, op_d;
  logic [23:0]       addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [POLL_W-1:0] pcnt_q, pcnt_d;
  logic              err_q, err_d;
  logic [7:0]        status_q, status_d;
  logic [8:0]        xfer_byte;
  logic [9:0]        page_end;
  logic              is_prog, stb;
  logic              unused_hi;

  assign is_prog   = (op_q == OP_PROG);
  assign page_end  = {2'b00, addr_q[7:0]} + {1'b0, cnt_q};
  assign unused_hi = ^sf.idata[31:8];

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      step_q   <= ST_WREN;
      op_q     <= OP_STATUS;
      addr_q   <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      err_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      err_q    <= err_d;
      status_q <= status_d;
    end
  end

  // Byte (with CS-release flag) for the current sequence slot.
  always_comb begin
    xfer_byte = 9'h000;
    case (step_q)
      ST_WREN:                   xfer_byte = 9'h006;
      ST_WREL, ST_CREL, ST_PREL: xfer_byte = 9'h100;
      ST_OPC:  xfer_byte = is_prog ? 9'h002 : 9'h020;
      ST_A2:   xfer_byte = {1'b0, addr_q[23:16]};
      ST_A1:   xfer_byte = is_prog ? {1'b0, addr_q[15:8]} : {1'b0, addr_q[15:12], 4'h0};
      ST_A0:   xfer_byte = is_prog ? {1'b0, addr_q[7:0]} : 9'h000;
      ST_DATA: xfer_byte = {1'b0, i_wdata};
      ST_RDSR: xfer_byte = 9'h005;
      default: xfer_byte = 9'h000;
    endcase
  end

  // Next-state: accept, validate, strobe/ack handshake, slot sequencing.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    op_d     = op_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    status_d = status_q;
    stb      = 1'b0;
    case (state_q)
      S_IDLE: if (i_cmd_valid) begin
        op_d    = i_cmd_op;
        addr_d  = i_cmd_addr;
        cnt_d   = (i_cmd_len == 9'd0) ? 9'd256 : i_cmd_len;
        err_d   = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (op_q == OP_RSVD || (is_prog && page_end > 10'd256)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          step_d  = (op_q == OP_STATUS) ? ST_RDSR : ST_WREN;
          state_d = S_STB;
        end
      end
      S_STB: begin
        // Data bytes wait for the host; a starved DATA phase keeps CS low.
        stb = (step_q == ST_DATA) ? i_wdata_valid : 1'b1;
        if (stb && !sf.stall) state_d = S_ACK;
      end
      S_ACK: if (sf.ack) begin
        state_d = S_STB;
        case (step_q)
          ST_A0:   step_d = is_prog ? ST_DATA : ST_CREL;
          ST_DATA: begin
            cnt_d = cnt_q - 9'd1;
            if (cnt_q == 9'd1) step_d = ST_CREL;
          end
          ST_CREL: begin
            pcnt_d = '0;
            step_d = ST_RDSR;
          end
          ST_POLL: begin
            status_d = sf.idata[7:0];
            if (op_q == OP_STATUS) step_d = ST_PREL;
            else begin
              pcnt_d = pcnt_q + POLL_W'(1);
              if (!sf.idata[0]) step_d = ST_PREL;
              else if (pcnt_q == POLL_W'(POLL_LIMIT-1)) begin
                err_d  = 1'b1;
                step_d = ST_PREL;
              end
            end
          end
          ST_PREL: state_d = S_DONE;
          default: step_d = step_q + 4'd1;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_cmd_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_err         = (state_q == S_DONE) && err_q;
  assign o_status      = status_q;
  assign o_wdata_ready = stb && !sf.stall && (step_q == ST_DATA);
  assign sf.cyc        = (state_q == S_STB) || (state_q == S_ACK);
  assign sf.we         = sf.cyc;
  assign sf.cfg_stb    = stb;
  assign sf.odata      = stb ? {23'h0, xfer_byte} : 32'h0;
endmodule

// File: tb/tb_spiflash_prog_seq.sv
// Directed bench for spiflash_prog_seq with a small spiflash slave model.
module tb_spiflash_prog_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, cmd_ready, wdata_valid, wdata_ready;
  logic        busy, done, err;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic [7:0]  wdata, status;

  spiflash_prog_seq_if sf();

  spiflash_prog_seq #(.POLL_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_status(status),
    .sf(sf)
  );

  int total = 0, bad = 0;
  logic [8:0] logmem [0:255];
  int n_log = 0;
  logic [7:0] rsp_mem [0:63];
  int rd_ptr = 0;
  logic [7:0] wmem [0:15];
  int wr_ptr = 0, wr_end = 0, gap = 0;
  int stall_at = -1, stall_len = 0, stall_cnt = 0;
  int n_rdy = 0, n_cyc = 0;
  logic acc_prev = 1'b0, in_read = 1'b0, took = 1'b0, acc_now;
  logic [7:0] rd_prev = 8'h00, rb;
  logic [8:0] exq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int base);
    chk({tag, "_len"}, n_log - base, exq.size());
    for (int i = 0; i < exq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {23'h0, logmem[base+i]}, {23'h0, exq[i]});
  endtask

  // Slave: stall/ack driven mid-cycle, transfers logged once settled.
  always @(negedge clk) begin
    sf.ack   = acc_prev;
    sf.idata = {24'h0, rd_prev};
    if (sf.cyc === 1'b1 && sf.cfg_stb === 1'b1 && n_log == stall_at && stall_cnt < stall_len) begin
      sf.stall = 1'b1;
      stall_cnt++;
    end else sf.stall = 1'b0;
    #1;
    acc_now = (sf.cyc === 1'b1) && (sf.cfg_stb === 1'b1) && !sf.stall && !rst;
    took    = (wdata_ready === 1'b1);
    if (took) n_rdy++;
    if (sf.cyc === 1'b1) begin
      n_cyc++;
      chk("we_with_cyc", sf.we, 1);
    end
    if (err === 1'b1) chk("err_only_with_done", done, 1);
    rb = 8'h00;
    if (acc_now) begin
      logmem[n_log] = sf.odata[8:0];
      n_log++;
      stall_cnt = 0;
      if (in_read && sf.odata == 32'h0) begin
        rb = rsp_mem[rd_ptr];
        rd_ptr++;
      end
      if (sf.odata == 32'h5) in_read = 1'b1;
      else if (sf.odata[8]) in_read = 1'b0;
    end
    if (sf.cyc !== 1'b1) in_read = 1'b0;
    acc_prev = acc_now;
    rd_prev  = rb;
  end

  // Host data feeder with idle gaps between bytes.
  always @(posedge clk) begin
    #1;
    if (took) begin
      wr_ptr++;
      gap = (wr_ptr % 2 == 1) ? 2 : 0;
    end
    if (gap > 0) begin
      wdata_valid = 1'b0;
      gap--;
    end else if (wr_ptr < wr_end) begin
      wdata_valid = 1'b1;
      wdata = wmem[wr_ptr];
    end else begin
      wdata_valid = 1'b0;
      wdata = 8'h00;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [8:0] l);
    @(posedge clk); #1;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output logic f, output logic e, output logic c);
    f = 1'b0; e = 1'bx; c = 1'bx;
    for (int n = 0; n < maxc && !f; n++) begin
      @(negedge clk); #2;
      if (done === 1'b1) begin
        f = 1'b1; e = err; c = sf.cyc;
      end
    end
  endtask

  task automatic reject(input string tag, input logic [1:0] op, input logic [23:0] a, input logic [8:0] l);
    int c0, b0;
    c0 = n_cyc; b0 = n_log;
    issue(op, a, l);
    @(negedge clk); #2;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_nodone"}, done, 0);
    @(negedge clk); #2;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 1);
    @(negedge clk); #2;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, cmd_ready, 1);
    chk({tag, "_nocyc"}, n_cyc - c0, 0);
    chk({tag, "_nolog"}, n_log - b0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic f, e, c;
    int base, r0;
    for (int i = 0; i < 64; i++) rsp_mem[i] = 8'h00;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cyc", sf.cyc, 0);
    chk("rst_stb", sf.cfg_stb, 0);
    chk("rst_data", sf.odata, 0);
    chk("rst_status", status, 0);
    @(posedge clk); #1 rst = 1'b0;

    // STATUS read returns 0x5A
    base = n_log; rsp_mem[rd_ptr] = 8'h5A;
    issue(2'b00, 24'h0, 9'd0);
    wait_done(200, f, e, c);
    chk("st_finished", f, 1);
    chk("st_err", e, 0);
    chk("st_cyc_in_done", c, 0);
    chk("st_status", status, 8'h5A);
    exq = '{9'h005, 9'h000, 9'h100};
    chk_log("st", base);

    // ERASE_4K with WIP busy for two reads
    base = n_log;
    rsp_mem[rd_ptr] = 8'h03; rsp_mem[rd_ptr+1] = 8'h03; rsp_mem[rd_ptr+2] = 8'h00;
    issue(2'b01, 24'h123456, 9'd0);
    wait_done(400, f, e, c);
    chk("er_finished", f, 1);
    chk("er_err", e, 0);
    chk("er_cyc_in_done", c, 0);
    chk("er_status", status, 8'h00);
    exq = '{9'h006, 9'h100, 9'h020, 9'h012, 9'h030, 9'h000, 9'h100,
            9'h005, 9'h000, 9'h000, 9'h000, 9'h100};
    chk_log("er", base);

    // PROGRAM 4 bytes with data gaps and a stalled second data byte
    base = n_log; r0 = n_rdy;
    rsp_mem[rd_ptr] = 8'h00;
    wmem[wr_end] = 8'hAA; wmem[wr_end+1] = 8'hBB; wmem[wr_end+2] = 8'hCC; wmem[wr_end+3] = 8'hDD;
    stall_at = base + 7; stall_len = 3;
    wr_end = wr_end + 4;
    issue(2'b10, 24'h000100, 9'd4);
    wait_done(600, f, e, c);
    stall_at = -1;
    chk("pg_finished", f, 1);
    chk("pg_err", e, 0);
    chk("pg_cyc_in_done", c, 0);
    chk("pg_ready_pulses", n_rdy - r0, 4);
    exq = '{9'h006, 9'h100, 9'h002, 9'h000, 9'h001, 9'h000, 9'h0AA, 9'h0BB,
            9'h0CC, 9'h0DD, 9'h100, 9'h005, 9'h000, 9'h100};
    chk_log("pg", base);

    // Validation failures
    reject("pagecross", 2'b10, 24'h0000FE, 9'd4);
    reject("rsvd_op", 2'b11, 24'h000000, 9'd1);
    reject("len0_256", 2'b10, 24'h000001, 9'd0);

    // Poll timeout: WIP never clears
    base = n_log;
    for (int i = 0; i < 8; i++) rsp_mem[rd_ptr+i] = 8'h01;
    issue(2'b01, 24'h0ABCDE, 9'd0);
    wait_done(400, f, e, c);
    chk("to_finished", f, 1);
    chk("to_err", e, 1);
    chk("to_cyc_in_done", c, 0);
    chk("to_status", status, 8'h01);
    exq = '{9'h006, 9'h100, 9'h020, 9'h00A, 9'h0B0, 9'h000, 9'h100,
            9'h005, 9'h000, 9'h000, 9'h000, 9'h000, 9'h100};
    chk_log("to", base);

    // Reset while starved in the DATA phase
    base = n_log;
    issue(2'b10, 24'h000010, 9'd4);
    f = 1'b0;
    for (int n = 0; n < 100 && !f; n++) begin
      @(negedge clk); #2;
      if (n_log - base >= 6) f = 1'b1;
    end
    chk("rs_reached_data", f, 1);
    repeat (5) @(negedge clk);
    #2;
    chk("rs_starve_cs_low", sf.cyc, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;
    chk("rs_cyc", sf.cyc, 0);
    chk("rs_ready", cmd_ready, 1);
    chk("rs_busy", busy, 0);
    chk("rs_status", status, 0);
    chk("rs_no_csrel", n_log - base, 6);

    base = n_log; rsp_mem[rd_ptr] = 8'h77;
    issue(2'b00, 24'h0, 9'd0);
    wait_done(200, f, e, c);
    chk("rs_st_finished", f, 1);
    chk("rs_st_err", e, 0);
    chk("rs_st_status", status, 8'h77);
    exq = '{9'h005, 9'h000, 9'h100};
    chk_log("rs_st", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
